mem_stage: RTL and testbench

- Memory-access pipeline stage: registers EX results into the EX->MEM pipeline register and issues loads/stores on the data-memory req/gnt/rvalid interface.
- Presents aligned, extended load data and register write enables to the write-back stage.
- Produces `valid_mem_o` as the write-back stage's bubble control.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, req/gnt/rvalid data-memory master,
// load-data alignment/extension and the stall/valid handshake toward EX and WB.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_ex_i,
  input  logic [4:0]  rd_addr_ex_i,
  input  logic [31:0] alu_result_ex_i,
  input  logic [31:0] mem_wdata_ex_i,
  input  logic        mem_req_ex_i,
  input  logic        mem_we_ex_i,
  input  logic [1:0]  mem_data_type_ex_i,
  input  logic        mem_sign_extend_ex_i,
  input  logic        reg_alu_wen_ex_i,
  input  logic        reg_mem_wen_ex_i,
  output logic        stall_mem_o,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  rd_addr_mem_o,
  output logic [31:0] alu_result_mem_o,
  output logic [31:0] mem_rdata_mem_o,
  output logic        reg_alu_wen_mem_o,
  output logic        reg_mem_wen_mem_o,
  output logic        valid_mem_o,
  output logic        misaligned_mem_o
);

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;

  localparam logic [1:0] StIdle       = 2'd0;
  localparam logic [1:0] StWaitGnt    = 2'd1;
  localparam logic [1:0] StWaitRvalid = 2'd2;

  logic        valid_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] alu_result_q;
  logic [31:0] wdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [1:0]  data_type_q;
  logic        sign_ext_q;
  logic        reg_alu_wen_q;
  logic        reg_mem_wen_q;
  logic [1:0]  state_q, state_d;

  logic [1:0]  off;
  logic        mis;
  logic        memop;
  logic        rsp_done;
  logic        stall;
  logic        req;
  logic        valid;
  logic        kill;
  logic        run;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_ext;

  assign off      = alu_result_q[1:0];
  assign mis      = ((data_type_q == HALF_WORD) && off[0]) || ((data_type_q == WORD) && (off != 2'b00));
  assign memop    = valid_q & mem_req_q & ~mis;
  assign rsp_done = (state_q == StWaitRvalid) & dmem_rvalid_i;
  assign stall    = memop & ~rsp_done;
  assign req      = ((state_q == StIdle) & memop) | (state_q == StWaitGnt);
  assign valid    = valid_q & (~mem_req_q | mis | rsp_done);
  assign kill     = valid_q & mem_req_q & mis;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (req && dmem_gnt_i) state_d = StWaitRvalid;
                    else if (req)          state_d = StWaitGnt;
      StWaitGnt:    if (dmem_gnt_i)        state_d = StWaitRvalid;
      StWaitRvalid: if (dmem_rvalid_i)     state_d = StIdle;
      default:                             state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      rd_addr_q     <= '0;
      alu_result_q  <= '0;
      wdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      data_type_q   <= BYTE;
      sign_ext_q    <= 1'b0;
      reg_alu_wen_q <= 1'b0;
      reg_mem_wen_q <= 1'b0;
      state_q       <= StIdle;
    end else begin
      if (!stall) begin
        valid_q       <= valid_ex_i;
        rd_addr_q     <= rd_addr_ex_i;
        alu_result_q  <= alu_result_ex_i;
        wdata_q       <= mem_wdata_ex_i;
        mem_req_q     <= mem_req_ex_i;
        mem_we_q      <= mem_we_ex_i;
        data_type_q   <= mem_data_type_ex_i;
        sign_ext_q    <= mem_sign_extend_ex_i;
        reg_alu_wen_q <= reg_alu_wen_ex_i;
        reg_mem_wen_q <= reg_mem_wen_ex_i;
      end
      state_q <= state_d;
    end
  end

  always_comb begin
    case (data_type_q)
      BYTE:      begin be = 4'b0001 << off; wdata_rep = {4{wdata_q[7:0]}};  end
      HALF_WORD: begin be = 4'b0011 << off; wdata_rep = {2{wdata_q[15:0]}}; end
      default:   begin be = 4'b1111;        wdata_rep = wdata_q;            end
    endcase
  end

  assign rdata_shift = dmem_rdata_i >> {off, 3'b000};

  always_comb begin
    case (data_type_q)
      BYTE:      rdata_ext = {{24{sign_ext_q & rdata_shift[7]}}, rdata_shift[7:0]};
      HALF_WORD: rdata_ext = {{16{sign_ext_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default:   rdata_ext = rdata_shift;
    endcase
  end

  // Outputs are forced to zero while reset is asserted, since the register only clears at the edge.
  assign run = ~rst_i;

  assign stall_mem_o       = run & stall;
  assign dmem_req_o        = run & req;
  assign dmem_addr_o       = (run & req) ? {alu_result_q[31:2], 2'b00} : '0;
  assign dmem_we_o         = run & req & mem_we_q;
  assign dmem_be_o         = (run & req) ? be : '0;
  assign dmem_wdata_o      = (run & req) ? wdata_rep : '0;
  assign rd_addr_mem_o     = run ? rd_addr_q : '0;
  assign alu_result_mem_o  = run ? alu_result_q : '0;
  assign mem_rdata_mem_o   = (run & valid) ? rdata_ext : '0;
  assign reg_alu_wen_mem_o = run & reg_alu_wen_q & ~kill;
  assign reg_mem_wen_mem_o = run & reg_mem_wen_q & ~kill;
  assign valid_mem_o       = run & valid;
  assign misaligned_mem_o  = run & kill;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized op streams checked
// against a byte-lane reference model.
module tb_mem_stage;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  typedef struct {
    bit          v;
    bit          req;
    bit          we;
    logic [1:0]  dt;
    bit          sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [4:0]  rd;
    bit          alu_wen;
    bit          mem_wen;
    int          gw;
    int          rw;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_ex_i;
  logic [4:0]  rd_addr_ex_i;
  logic [31:0] alu_result_ex_i;
  logic [31:0] mem_wdata_ex_i;
  logic        mem_req_ex_i;
  logic        mem_we_ex_i;
  logic [1:0]  mem_data_type_ex_i;
  logic        mem_sign_extend_ex_i;
  logic        reg_alu_wen_ex_i;
  logic        reg_mem_wen_ex_i;
  logic        stall_mem_o;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  rd_addr_mem_o;
  logic [31:0] alu_result_mem_o;
  logic [31:0] mem_rdata_mem_o;
  logic        reg_alu_wen_mem_o;
  logic        reg_mem_wen_mem_o;
  logic        valid_mem_o;
  logic        misaligned_mem_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;
  op_t         seq[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .valid_ex_i           (valid_ex_i),
    .rd_addr_ex_i         (rd_addr_ex_i),
    .alu_result_ex_i      (alu_result_ex_i),
    .mem_wdata_ex_i       (mem_wdata_ex_i),
    .mem_req_ex_i         (mem_req_ex_i),
    .mem_we_ex_i          (mem_we_ex_i),
    .mem_data_type_ex_i   (mem_data_type_ex_i),
    .mem_sign_extend_ex_i (mem_sign_extend_ex_i),
    .reg_alu_wen_ex_i     (reg_alu_wen_ex_i),
    .reg_mem_wen_ex_i     (reg_mem_wen_ex_i),
    .stall_mem_o          (stall_mem_o),
    .dmem_req_o           (dmem_req_o),
    .dmem_gnt_i           (dmem_gnt_i),
    .dmem_addr_o          (dmem_addr_o),
    .dmem_we_o            (dmem_we_o),
    .dmem_be_o            (dmem_be_o),
    .dmem_wdata_o         (dmem_wdata_o),
    .dmem_rvalid_i        (dmem_rvalid_i),
    .dmem_rdata_i         (dmem_rdata_i),
    .rd_addr_mem_o        (rd_addr_mem_o),
    .alu_result_mem_o     (alu_result_mem_o),
    .mem_rdata_mem_o      (mem_rdata_mem_o),
    .reg_alu_wen_mem_o    (reg_alu_wen_mem_o),
    .reg_mem_wen_mem_o    (reg_mem_wen_mem_o),
    .valid_mem_o          (valid_mem_o),
    .misaligned_mem_o     (misaligned_mem_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] dt);
    if (dt == BYTE) return 1;
    if (dt == HALF) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input op_t o);
    return (o.addr % size_of(o.dt)) != 0;
  endfunction

  // Reference model: lanes covered by the access, data replicated per access size.
  function automatic logic [3:0] exp_be(input op_t o);
    logic [3:0] b;
    int s = size_of(o.dt);
    int off = int'(o.addr[1:0]);
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + s);
    return b;
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    logic [31:0] w;
    int s = size_of(o.dt);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = o.wd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input op_t o);
    logic [31:0] val = '0;
    int s = size_of(o.dt);
    int off = int'(o.addr[1:0]);
    for (int i = 0; i < s; i++) val[8*i +: 8] = o.rdat[8*(off+i) +: 8];
    if (o.sx && s < 4 && val[8*s-1])
      for (int i = s; i < 4; i++) val[8*i +: 8] = 8'hFF;
    return val;
  endfunction

  function automatic op_t mk(input bit v, input bit req, input bit we, input logic [1:0] dt,
                             input bit sx, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int gw, input int rw);
    op_t o;
    o.v = v; o.req = req; o.we = we; o.dt = dt; o.sx = sx;
    o.addr = addr; o.wd = wd; o.rdat = rdat; o.gw = gw; o.rw = rw;
    o.rd = 5'($urandom);
    o.alu_wen = !req;
    o.mem_wen = req && !we;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int kind = $urandom_range(0, 2);
    logic [1:0] dt = 2'($urandom_range(0, 2));
    logic [31:0] a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(dt) - 1);
    o = mk($urandom_range(0, 7) != 0, kind != 0, kind == 2, dt, 1'($urandom), a, $urandom,
           $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    if (kind == 0) o.alu_wen = 1'($urandom);
    return o;
  endfunction

  task automatic drive_ex(input op_t o);
    valid_ex_i           = o.v;
    rd_addr_ex_i         = o.rd;
    alu_result_ex_i      = o.addr;
    mem_wdata_ex_i       = o.wd;
    mem_req_ex_i         = o.req;
    mem_we_ex_i          = o.we;
    mem_data_type_ex_i   = o.dt;
    mem_sign_extend_ex_i = o.sx;
    reg_alu_wen_ex_i     = o.alu_wen;
    reg_mem_wen_ex_i     = o.mem_wen;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk1({tag, "_stall"}, stall_mem_o, 1'b0);
    chk1({tag, "_req"}, dmem_req_o, 1'b0);
    chk1({tag, "_we"}, dmem_we_o, 1'b0);
    chk1({tag, "_valid"}, valid_mem_o, 1'b0);
    chk1({tag, "_mis"}, misaligned_mem_o, 1'b0);
    chk1({tag, "_alu_wen"}, reg_alu_wen_mem_o, 1'b0);
    chk1({tag, "_mem_wen"}, reg_mem_wen_mem_o, 1'b0);
    chk({tag, "_addr"}, dmem_addr_o, 32'h0);
    chk({tag, "_be"}, 32'(dmem_be_o), 32'h0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'h0);
    chk({tag, "_rd"}, 32'(rd_addr_mem_o), 32'h0);
    chk({tag, "_alu"}, alu_result_mem_o, 32'h0);
    chk({tag, "_rdata"}, mem_rdata_mem_o, 32'h0);
  endtask

  // Runs the MEM-stage lifetime of one op; the caller has already placed the follow-on op in EX.
  task automatic mem_phase(input op_t o);
    bit mis = o.req && is_mis(o);
    bit memop = o.v && o.req && !mis;
    if (!memop) begin
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      @(negedge clk);
      chk1("np_valid", valid_mem_o, o.v);
      chk1("np_stall", stall_mem_o, 1'b0);
      chk1("np_req", dmem_req_o, 1'b0);
      chk1("np_misaligned", misaligned_mem_o, o.v && mis);
      if (o.v) begin
        chk("np_rd", 32'(rd_addr_mem_o), 32'(o.rd));
        chk("np_alu", alu_result_mem_o, o.addr);
        chk1("np_alu_wen", reg_alu_wen_mem_o, o.alu_wen && !mis);
        chk1("np_mem_wen", reg_mem_wen_mem_o, o.mem_wen && !mis);
      end
      tick();
    end else begin
      for (int k = 0; k <= o.gw; k++) begin
        dmem_gnt_i = (k == o.gw);
        dmem_rvalid_i = 1'($urandom);  // stray responses before grant must be ignored
        dmem_rdata_i = $urandom;
        @(negedge clk);
        chk1("req", dmem_req_o, 1'b1);
        chk("addr", dmem_addr_o, {o.addr[31:2], 2'b00});
        chk("be", 32'(dmem_be_o), 32'(exp_be(o)));
        chk("wdata", dmem_wdata_o, exp_wdata(o));
        chk1("we", dmem_we_o, o.we);
        chk1("gnt_stall", stall_mem_o, 1'b1);
        chk1("gnt_valid", valid_mem_o, 1'b0);
        tick();
      end
      dmem_gnt_i = 1'b0;
      for (int j = 0; j <= o.rw; j++) begin
        dmem_rvalid_i = (j == o.rw);
        dmem_rdata_i = (j == o.rw) ? o.rdat : $urandom;
        @(negedge clk);
        chk1("rsp_req", dmem_req_o, 1'b0);
        chk1("rsp_stall", stall_mem_o, j != o.rw);
        chk1("rsp_valid", valid_mem_o, j == o.rw);
        if (j == o.rw) begin
          chk1("rsp_misaligned", misaligned_mem_o, 1'b0);
          chk("rsp_rd", 32'(rd_addr_mem_o), 32'(o.rd));
          chk("rsp_alu", alu_result_mem_o, o.addr);
          chk1("rsp_alu_wen", reg_alu_wen_mem_o, o.alu_wen);
          chk1("rsp_mem_wen", reg_mem_wen_mem_o, o.mem_wen);
          if (!o.we) begin
            chk("load_data", mem_rdata_mem_o, exp_load(o));
            last_rdata = mem_rdata_mem_o;
          end
        end
        tick();
      end
      dmem_rvalid_i = 1'b0;
    end
  endtask

  task automatic run_seq();
    op_t bub = mk(0, 0, 0, BYTE, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    drive_ex(seq[0]);
    @(negedge clk);
    chk1("bubble_valid", valid_mem_o, 1'b0);
    tick();
    for (int i = 0; i < seq.size(); i++) begin
      if (i + 1 < seq.size()) drive_ex(seq[i+1]);
      else drive_ex(bub);
      mem_phase(seq[i]);
    end
    seq.delete();
  endtask

  initial begin
    op_t bub = mk(0, 0, 0, BYTE, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    rst_i = 1'b1;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    drive_ex(bub);
    tick();
    check_zero("rst");
    tick();
    rst_i = 1'b0;
    check_zero("post_rst");
    tick();

    // Word load, zero wait
    seq.push_back(mk(1, 1, 0, WORD, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0));
    run_seq();
    chk("lw_lit", last_rdata, 32'hDEADBEEF);

    // Signed/unsigned byte and signed half loads
    seq.push_back(mk(1, 1, 0, BYTE, 1, 32'h103, 32'h0, 32'h80123456, 0, 0));
    run_seq();
    chk("lb_lit", last_rdata, 32'hFFFFFF80);
    seq.push_back(mk(1, 1, 0, BYTE, 0, 32'h103, 32'h0, 32'h80123456, 0, 0));
    run_seq();
    chk("lbu_lit", last_rdata, 32'h00000080);
    seq.push_back(mk(1, 1, 0, HALF, 1, 32'h102, 32'h0, 32'h80011234, 0, 0));
    run_seq();
    chk("lh_lit", last_rdata, 32'hFFFF8001);

    // Halfword store with grant withheld 3 cycles
    seq.push_back(mk(1, 1, 1, HALF, 0, 32'h206, 32'h0000ABCD, 32'h0, 3, 0));
    run_seq();

    // Misaligned word load
    seq.push_back(mk(1, 1, 0, WORD, 0, 32'h102, 32'h0, 32'h12345678, 0, 0));
    run_seq();

    // Bubble, then back-to-back loads
    seq.push_back(bub);
    seq.push_back(mk(1, 1, 0, WORD, 0, 32'h400, 32'h0, 32'h11112222, 0, 0));
    seq.push_back(mk(1, 1, 0, WORD, 0, 32'h404, 32'h0, 32'h33334444, 0, 0));
    run_seq();
    chk("b2b_lit", last_rdata, 32'h33334444);

    // Reset while waiting for the response
    drive_ex(mk(1, 1, 0, WORD, 0, 32'h300, 32'h0, 32'h0, 0, 0));
    tick();
    drive_ex(bub);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk1("rst_mid_req", dmem_req_o, 1'b1);
    tick();
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    check_zero("rst_mid");
    tick();
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    check_zero("rst_mid_after");
    tick();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk1("rst_mid_idle_req", dmem_req_o, 1'b0);
    chk1("rst_mid_idle_valid", valid_mem_o, 1'b0);
    tick();

    // Randomized op stream
    for (int n = 0; n < 80; n++) seq.push_back(rnd_op());
    run_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
